// File: rtl/mem_lane_arbiter_if.sv
// Request/response bundle for the two memory requesters: instruction fetch (A)
// and read/write data (B).
interface mem_lane_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  a_req;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_ack;
  logic                  a_rvalid;
  logic [31:0]           a_rdata;

  logic                  b_req;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [3:0]            b_we;
  logic [31:0]           b_wdata;
  logic                  b_ack;
  logic                  b_rvalid;
  logic [31:0]           b_rdata;

  modport master (
    output a_req, a_addr, b_req, b_addr, b_we, b_wdata,
    input  a_ack, a_rvalid, a_rdata, b_ack, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_addr, b_req, b_addr, b_we, b_wdata,
    output a_ack, a_rvalid, a_rdata, b_ack, b_rvalid, b_rdata
  );
endinterface

// File: rtl/mem_lane_arbiter.sv
// Round-robin arbiter sharing four byte-lane RAMs between a fetch port and a
// data port, with an embedded sequencer that fills the memory with a constant.
module mem_lane_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter logic [31:0] CLEAR_VALUE = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_lane_arbiter_if.slave     bus,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_we,
  input  logic [31:0]           mem_dout
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  localparam logic [0:0] GrantA = 1'b0;
  localparam logic [0:0] GrantB = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [0:0]            last_grant_q, last_grant_d;
  logic                  a_rvalid_q, b_rvalid_q, clear_done_q;
  logic                  grant_a, grant_b;
  logic                  cnt_last;

  assign cnt_last = &cnt_q;

  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mem_addr     = '0;
    mem_we       = 4'h0;
    mem_din      = bus.b_wdata;

    unique case (state_q)
      StIdle: begin
        // On conflict, the port that did not win last time goes first.
        grant_a = bus.a_req & (~bus.b_req | (last_grant_q == GrantB));
        grant_b = bus.b_req & (~bus.a_req | (last_grant_q == GrantA));
        if (grant_a) begin
          mem_addr     = bus.a_addr;
          last_grant_d = GrantA;
        end else if (grant_b) begin
          mem_addr     = bus.b_addr;
          mem_we       = bus.b_we;
          last_grant_d = GrantB;
        end
        if (clear_start) begin
          state_d = StClear;
        end
      end
      StClear: begin
        mem_addr = cnt_q;
        mem_we   = 4'hF;
        mem_din  = CLEAR_VALUE;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= GrantA;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      a_rvalid_q   <= grant_a;
      b_rvalid_q   <= grant_b & (bus.b_we == 4'h0);
      clear_done_q <= (state_q == StClear) & cnt_last;
    end
  end

  assign bus.a_ack    = grant_a;
  assign bus.b_ack    = grant_b;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  // RAM read address is registered inside the lanes, so data is already aligned.
  assign bus.a_rdata  = mem_dout;
  assign bus.b_rdata  = mem_dout;
  assign clear_busy   = (state_q == StClear);
  assign clear_done   = clear_done_q;

endmodule

// File: tb/tb_mem_lane_arbiter.sv
// Scoreboard bench for mem_lane_arbiter with a four-lane byte RAM model that
// registers its read address.
module tb_mem_lane_arbiter;
  localparam int unsigned AW = 4;
  localparam logic [31:0] CV = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_lane_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  logic          clear_start;
  logic          clear_busy;
  logic          clear_done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;
  logic [3:0]    mem_we;

  mem_lane_arbiter #(
    .ADDR_WIDTH  (AW),
    .CLEAR_VALUE (CV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_dout    (mem_dout)
  );

  // Byte-lane RAM model
  logic [31:0]   mem_arr [16];
  logic [AW-1:0] rd_addr_q;
  logic          init_mem;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 32'h1000_0000 + 32'(i);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mem_we[k]) mem_arr[mem_addr][8*k +: 8] <= mem_din[8*k +: 8];
      end
    end
    rd_addr_q <= mem_addr;
  end
  assign mem_dout = mem_arr[rd_addr_q];

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every rvalid must match the oldest outstanding read of that port.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.a_rvalid) begin
        if (qa.size() == 0) check("a_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          e = qa.pop_front();
          check("a_rdata", bus.a_rdata, e.d);
          check("a_rvalid_latency", cyc, e.c);
        end
      end
      if (bus.b_rvalid) begin
        if (qb.size() == 0) check("b_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          e = qb.pop_front();
          check("b_rdata", bus.b_rdata, e.d);
          check("b_rvalid_latency", cyc, e.c);
        end
      end
    end
  end

  task automatic wait_a(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.a_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.a_ack;
    if (!ok) check("a_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_b(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.b_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.b_ack;
    if (!ok) check("b_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_a(input logic [AW-1:0] addr, input logic [31:0] exp);
    bit ok;
    bus.a_req  = 1'b1;
    bus.a_addr = addr;
    wait_a(ok);
    if (ok) qa.push_back('{d: exp, c: cyc + 1});
    @(posedge clk);
    #1 bus.a_req = 1'b0;
  endtask

  task automatic b_op(input logic [AW-1:0] addr, input logic [3:0] we,
                      input logic [31:0] wdata, input logic [31:0] exp);
    bit ok;
    bus.b_req   = 1'b1;
    bus.b_addr  = addr;
    bus.b_we    = we;
    bus.b_wdata = wdata;
    wait_b(ok);
    if (ok && we == 4'h0) qb.push_back('{d: exp, c: cyc + 1});
    @(posedge clk);
    #1 bus.b_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  busy_cnt;
    int  done_cnt;
    bit  done_seen;
    clear_start = 1'b0;
    init_mem    = 1'b1;
    bus.a_req   = 1'b1;
    bus.a_addr  = 4'd1;
    bus.b_req   = 1'b1;
    bus.b_addr  = 4'd2;
    bus.b_we    = 4'h0;
    bus.b_wdata = 32'h0;

    @(posedge clk);
    #1 init_mem = 1'b0;
    @(negedge clk);
    check("reset_a_rvalid", bus.a_rvalid, 1'b0);
    check("reset_b_rvalid", bus.b_rvalid, 1'b0);
    check("reset_clear_busy", clear_busy, 1'b0);
    check("reset_clear_done", clear_done, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Conflict from reset release: B, A, B, A
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("conflict_a_ack", bus.a_ack, (i % 2) == 1);
      check("conflict_b_ack", bus.b_ack, (i % 2) == 0);
      if (bus.a_ack) qa.push_back('{d: 32'h1000_0001, c: cyc + 1});
      if (bus.b_ack) qb.push_back('{d: 32'h1000_0002, c: cyc + 1});
    end
    @(posedge clk);
    #1;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;

    b_op(4'd5, 4'hF, 32'h1122_3344, 32'h0);
    rd_a(4'd5, 32'h1122_3344);

    b_op(4'd7, 4'hF, 32'hAABB_CCDD, 32'h0);
    b_op(4'd7, 4'b0101, 32'h1122_3344, 32'h0);
    b_op(4'd7, 4'h0, 32'h0, 32'hAA22_CC44);

    b_op(4'd3, 4'hF, 32'h5A5A_5A5A, 32'h0);
    b_op(4'd3, 4'h0, 32'h0, 32'h5A5A_5A5A);
    repeat (2) @(posedge clk);
    #1;

    // Clear started together with a B read; A held off until clear_done
    clear_start = 1'b1;
    bus.b_req   = 1'b1;
    bus.b_addr  = 4'd2;
    bus.b_we    = 4'h0;
    @(negedge clk);
    check("clear_start_b_ack", bus.b_ack, 1'b1);
    if (bus.b_ack) qb.push_back('{d: 32'h1000_0002, c: cyc + 1});
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    bus.b_req   = 1'b0;
    bus.a_req   = 1'b1;
    bus.a_addr  = 4'd9;
    busy_cnt    = 0;
    done_cnt    = 0;
    done_seen   = 1'b0;
    for (int n = 0; n < 40 && !done_seen; n++) begin
      @(negedge clk);
      if (clear_busy) begin
        busy_cnt++;
        check("no_ack_in_clear", bus.a_ack, 1'b0);
        // A second start while clearing must not extend the clear.
        clear_start = (busy_cnt == 4);
      end
      if (clear_done) begin
        done_cnt++;
        done_seen = 1'b1;
        check("ack_with_done", bus.a_ack, 1'b1);
        check("busy_low_at_done", clear_busy, 1'b0);
        if (bus.a_ack) qa.push_back('{d: CV, c: cyc + 1});
      end
    end
    check("clear_cycles", busy_cnt, 32'd16);
    check("clear_done_pulses", done_cnt, 32'd1);
    @(posedge clk);
    #1 bus.a_req = 1'b0;
    @(negedge clk);
    check("clear_done_one_cycle", clear_done, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) rd_a(4'(i), CV);

    // Reset during clear cycle 6
    for (int i = 0; i < 16; i++) b_op(4'(i), 4'hF, 32'hC0DE_0000 + 32'(i), 32'h0);
    clear_start = 1'b1;
    @(posedge clk);
    #1 clear_start = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_before_reset", clear_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midclear_busy", clear_busy, 1'b0);
    check("midclear_done", clear_done, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("no_done_after_abort", clear_done, 1'b0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) rd_a(4'(i), (i < 6) ? CV : 32'hC0DE_0000 + 32'(i));

    repeat (3) @(posedge clk);
    check("a_queue_drained", qa.size(), 32'd0);
    check("b_queue_drained", qb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_lane_arbiter.md
Name: mem_lane_arbiter

Overview:
- Shares one 32-bit word memory between two requesters:
  - an instruction-fetch port (A), read only;
  - a data port (B), read/write with byte enables.
- The memory is built from four 8-bit single-port byte-lane RAMs with a registered read address, so read data arrives one cycle after the address is presented.
- Arbitration is round-robin.
- An embedded clear sequencer can fill the whole memory with a constant before the CPU is released from boot.

Parameters:
- ADDR_WIDTH, 14, word address width; memory depth is 2**ADDR_WIDTH words.
- CLEAR_VALUE, 32'h0, word written to every location by the clear sequencer.

Ports:
- clk  input  1  single clock for the block and the memory lanes.
- reset  input  1  asynchronous, active-high reset.
- a_req  input  1  port A read request; held until a_ack.
- a_addr  input  ADDR_WIDTH  port A word address.
- a_ack  output  1  port A request accepted this cycle (combinational).
- a_rvalid  output  1  port A read data valid (registered).
- a_rdata  output  32  port A read data.
- b_req  input  1  port B request; held until b_ack.
- b_addr  input  ADDR_WIDTH  port B word address.
- b_we  input  4  port B byte write enables; 0 = read.
- b_wdata  input  32  port B write data.
- b_ack  output  1  port B request accepted this cycle (combinational).
- b_rvalid  output  1  port B read data valid (registered).
- b_rdata  output  32  port B read data.
- clear_start  input  1  pulse; starts a memory clear.
- clear_busy  output  1  clear in progress.
- clear_done  output  1  one-cycle pulse when the clear completes.
- mem_addr  output  ADDR_WIDTH  to all four lanes.
- mem_din  output  32  byte k drives lane k.
- mem_we  output  4  bit k is the write enable for lane k.
- mem_dout  input  32  concatenated lane outputs.

Behaviour:
- States: IDLE, CLEAR. Reset enters IDLE.
- Reset values:
  - a_rvalid, b_rvalid, clear_busy, clear_done = 0;
  - clear counter = 0;
  - last_grant = A, so the first conflict after reset goes to B.
- IDLE, arbitration (combinational from req and last_grant):
  - Only a_req high: grant A.
  - Only b_req high: grant B.
  - Both high: grant the port not equal to last_grant.
  - last_grant updates on each grant at the clock edge.
- Granted port:
  - ack is high this cycle;
  - mem_addr = its address;
  - mem_we = b_we for B, 4'b0000 for A;
  - mem_din = b_wdata.
- No grant: mem_we = 0 and mem_addr = 0. mem_addr is don't-care for verification.
- Read latency: when a read is granted in cycle N, the matching rvalid is high in cycle N+1 and rdata = mem_dout in that cycle.
  - a_rdata and b_rdata both pass mem_dout through unregistered.
  - Only the rvalid of the granted port rises.
- B writes (b_we != 0):
  - complete in the grant cycle; no b_rvalid;
  - only enabled lanes are written, other bytes are unchanged.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
  - With both ports requesting continuously, grants alternate A, B, A, B…
  - The worst-case wait is 1 cycle.
- Requesters must hold req/addr/we/wdata stable until ack. A request dropped before ack is simply never served.
- clear_start in IDLE:
  - enters CLEAR on the next edge;
  - any grant in that same cycle still completes normally, including its rvalid one cycle later.
- CLEAR:
  - clear_busy = 1; a_ack = b_ack = 0; pending requests are held off.
  - Each cycle: mem_addr = counter, mem_we = 4'hF, mem_din = CLEAR_VALUE; counter increments.
  - After writing address 2**ADDR_WIDTH-1: clear_done pulses for one cycle (the first IDLE cycle), counter wraps to 0, state returns to IDLE.
  - Arbitration resumes in that same IDLE cycle.
  - A clear takes exactly 2**ADDR_WIDTH cycles.
- clear_start while in CLEAR is ignored.
- Simultaneous clear_start and requests in IDLE: the requests are arbitrated and acked that cycle; CLEAR begins next cycle.
- Reset asserted mid-clear or mid-read:
  - immediately returns to IDLE with all outputs at their reset values;
  - in-flight rvalid is cancelled; the clear is left partial, with no clear_done.
- last_grant is not modified in CLEAR.

Test Plan:
- Single read A: write word 0x11223344 to addr 5 via B (b_we=4'hF), then a_req addr 5 → a_ack in cycle N; a_rvalid=1 and a_rdata=0x11223344 in N+1.
- Byte write: addr 7 holds 0xAABBCCDD; B writes b_we=4'b0101, b_wdata=0x11223344 → a later B read of addr 7 returns 0xAA22CC44, with b_rvalid one cycle after b_ack.
- Conflict after reset: a_req and b_req both held high for 4 cycles from reset release → ack order B, A, B, A; each read's rvalid lags its ack by exactly 1 cycle.
- Clear (ADDR_WIDTH=4, CLEAR_VALUE=0xDEADBEEF): pulse clear_start with a_req held → clear_busy high for 16 cycles, no a_ack during it, clear_done pulses once, a_ack in that same cycle, all 16 addresses read back 0xDEADBEEF.
- Reset mid-clear: assert reset at clear cycle 6 → clear_busy=0 and no clear_done; addresses 0–5 hold CLEAR_VALUE, the rest keep old data.
- Write then read same address on consecutive cycles via B: B write 0x5A5A5A5A to addr 3 (cycle N), B read addr 3 (N+1) → b_rdata=0x5A5A5A5A in N+2.
